// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin arbiter sharing one 8-bit FIFO write port among NUM_REQ
// valid/ready producers. A winner owns the port for up to MAX_BURST beats,
// then gives it up for one IDLE cycle so the next requester can be chosen.
// The FIFO full flag gates ready/write_enable combinationally, so no beat is
// ever presented to a full FIFO.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int GW        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 fifo_full,
  output logic [7:0]           fifo_wdata,
  output logic                 fifo_write_enable,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic [15:0]          beat_count
);

  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_BURST  = 1'b1;
  localparam logic [3:0]    LAST_BEAT = 4'(MAX_BURST - 1);
  localparam logic [GW-1:0] LAST_IDX  = GW'(NUM_REQ - 1);

  logic [0:0]    state_r;
  logic [GW-1:0] owner_r;
  logic [GW-1:0] last_grant_r;
  logic [3:0]    burst_cnt_r;
  logic [15:0]   beat_count_r;

  logic          in_burst_s;
  logic          owner_valid_s;
  logic [7:0]    owner_data_s;
  logic          xfer_s;
  logic          any_req_s;
  logic [GW-1:0] winner_s;

  assign in_burst_s    = (state_r == ST_BURST);
  assign owner_valid_s = req_valid[owner_r];
  assign owner_data_s  = req_data[{owner_r, 3'b000} +: 8];
  assign xfer_s        = in_burst_s & owner_valid_s & ~fifo_full;
  assign any_req_s     = |req_valid;

  // Pick the first requester after last_grant, wrapping; last_grant itself is
  // visited last so the previous owner has the lowest priority.
  always_comb begin
    logic [GW-1:0] idx_v;
    logic          found_v;
    winner_s = last_grant_r;
    found_v  = 1'b0;
    idx_v    = last_grant_r;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_v = last_grant_r + GW'(k);
      if (!found_v && req_valid[idx_v]) begin
        winner_s = idx_v;
        found_v  = 1'b1;
      end else begin
        found_v  = found_v;
      end
    end
  end

  // Steer the owner's ready and data; full blocks the handshake this cycle.
  always_comb begin
    req_ready  = {NUM_REQ{1'b0}};
    fifo_wdata = 8'h00;
    if (in_burst_s) begin
      fifo_wdata = owner_data_s;
      if (!fifo_full) begin
        req_ready[owner_r] = 1'b1;
      end else begin
        req_ready = {NUM_REQ{1'b0}};
      end
    end else begin
      fifo_wdata = 8'h00;
    end
  end

  assign fifo_write_enable = xfer_s;
  assign grant_id          = owner_r;
  assign busy              = in_burst_s;
  assign beat_count        = beat_count_r;

  // Grant/burst state machine and the free-running beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      owner_r      <= {GW{1'b0}};
      last_grant_r <= LAST_IDX;
      burst_cnt_r  <= 4'd0;
      beat_count_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s && !fifo_full) begin
            owner_r     <= winner_s;
            burst_cnt_r <= 4'd0;
            state_r     <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (xfer_s) begin
            beat_count_r <= beat_count_r + 16'd1;
            burst_cnt_r  <= burst_cnt_r + 4'd1;
            if (burst_cnt_r == LAST_BEAT) begin
              state_r      <= ST_IDLE;
              last_grant_r <= owner_r;
            end
          end else if (!owner_valid_s) begin
            // Owner ran dry: release early so others are not starved.
            state_r      <= ST_IDLE;
            last_grant_r <= owner_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
